// File: rtl/ws2812_pkg.sv
// Shared types and default timing for the WS2812 serial encoder.
// Holds the FSM state enum, the colour word type and the wire-order helper.
// Optional macro WS2812_GRB_ORDER_EN: reorder {R,G,B} words to {G,R,B}.
package ws2812_pkg;

    typedef enum logic [1:0] {
        IDLE,
        HIGH,
        LOW,
        LATCH
    } state_t;

    typedef logic [23:0] color_t;

    localparam int T0H_DEF   = 20;
    localparam int T1H_DEF   = 40;
    localparam int BIT_DEF   = 62;
    localparam int RESET_DEF = 2500;
    localparam int LED_DEF   = 8;

    function automatic color_t wire_order(color_t c);
`ifdef WS2812_GRB_ORDER_EN
        return {c[15:8], c[23:16], c[7:0]};
`else
        return c;
`endif
    endfunction

endpackage

// File: rtl/ws2812_pulse_timer.sv
// Loadable down-counter that times the HIGH, LOW and LATCH phases.
// Ports: clk, rst_n, load, load_val (cycles-1), tc (count is zero).
module ws2812_pulse_timer #(
    parameter int W = 12
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         tc
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign tc = (cnt_q == '0);

endmodule

// File: rtl/ws2812_bit_encoder.sv
// WS2812 pulse-width line encoder: 24-bit words in via valid/ready, MSB-first
// serial out on dout, latch period after the last word of a refresh.
// Ports: clk, rst_n, frame_in/frame_valid/frame_ready, led_index, dout,
// busy, frame_done, underrun. Macro WS2812_GRB_ORDER_EN selects GRB order.
module ws2812_bit_encoder
    import ws2812_pkg::*;
#(
    parameter int T0H_CYC   = T0H_DEF,
    parameter int T1H_CYC   = T1H_DEF,
    parameter int BIT_CYC   = BIT_DEF,
    parameter int RESET_CYC = RESET_DEF,
    parameter int LED_COUNT = LED_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [23:0] frame_in,
    input  logic        frame_valid,
    output logic        frame_ready,
    output logic [2:0]  led_index,
    output logic        dout,
    output logic        busy,
    output logic        frame_done,
    output logic        underrun
);

    localparam int MAX_CYC = (BIT_CYC > RESET_CYC) ? BIT_CYC : RESET_CYC;
    localparam int TW      = $clog2(MAX_CYC + 1);

    // Timer load values are phase length minus one.
    localparam logic [TW-1:0] HI0 = TW'(T0H_CYC - 1);
    localparam logic [TW-1:0] HI1 = TW'(T1H_CYC - 1);
    localparam logic [TW-1:0] LO0 = TW'(BIT_CYC - T0H_CYC - 1);
    localparam logic [TW-1:0] LO1 = TW'(BIT_CYC - T1H_CYC - 1);
    localparam logic [TW-1:0] LAT = TW'(RESET_CYC - 1);
    localparam logic [2:0]    LAST_W = 3'(LED_COUNT - 1);

    state_t        state_q, state_nxt;
    color_t        hold_q, shift_q, load_word;
    logic          full_q;
    logic [4:0]    bit_q;
    logic [2:0]    word_q, idx_q;
    logic          dout_q, urun_q, done_q;

    logic          accept, load, shift_en, word_inc, word_clr;
    logic          urun_nxt, done_nxt;
    logic          tmr_load, tmr_tc;
    logic [TW-1:0] tmr_val;

    assign accept      = frame_valid & ~full_q;
    assign load_word   = wire_order(hold_q);
    assign frame_ready = ~full_q;
    assign led_index   = idx_q;
    assign dout        = dout_q;
    assign busy        = (state_q != IDLE);
    assign frame_done  = done_q;
    assign underrun    = urun_q;

    ws2812_pulse_timer #(.W(TW)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (tmr_val),
        .tc       (tmr_tc)
    );

    always_comb begin
        state_nxt = state_q;
        load      = 1'b0;
        shift_en  = 1'b0;
        word_inc  = 1'b0;
        word_clr  = 1'b0;
        urun_nxt  = 1'b0;
        done_nxt  = 1'b0;
        tmr_load  = 1'b0;
        tmr_val   = '0;
        unique case (state_q)
            IDLE: begin
                if (full_q) begin
                    load      = 1'b1;
                    tmr_load  = 1'b1;
                    tmr_val   = load_word[23] ? HI1 : HI0;
                    state_nxt = HIGH;
                end
            end
            HIGH: begin
                if (tmr_tc) begin
                    tmr_load  = 1'b1;
                    tmr_val   = shift_q[23] ? LO1 : LO0;
                    state_nxt = LOW;
                end
            end
            LOW: begin
                if (tmr_tc) begin
                    tmr_load = 1'b1;
                    if (bit_q != 5'd23) begin
                        shift_en  = 1'b1;
                        tmr_val   = shift_q[22] ? HI1 : HI0;
                        state_nxt = HIGH;
                    end else if (word_q == LAST_W) begin
                        tmr_val   = LAT;
                        state_nxt = LATCH;
                    end else if (full_q) begin
                        // Next word follows with no gap.
                        load      = 1'b1;
                        word_inc  = 1'b1;
                        tmr_val   = load_word[23] ? HI1 : HI0;
                        state_nxt = HIGH;
                    end else begin
                        urun_nxt  = 1'b1;
                        tmr_val   = LAT;
                        state_nxt = LATCH;
                    end
                end
            end
            LATCH: begin
                if (tmr_tc) begin
                    done_nxt  = 1'b1;
                    word_clr  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            hold_q  <= '0;
            shift_q <= '0;
            full_q  <= 1'b0;
            bit_q   <= '0;
            word_q  <= '0;
            idx_q   <= '0;
            dout_q  <= 1'b0;
            urun_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_nxt;
            dout_q  <= (state_nxt == HIGH);
            urun_q  <= urun_nxt;
            done_q  <= done_nxt;
            full_q  <= accept | (full_q & ~load);
            if (accept) begin
                hold_q <= frame_in;
            end
            if (load) begin
                shift_q <= load_word;
                bit_q   <= '0;
            end else if (shift_en) begin
                shift_q <= {shift_q[22:0], 1'b0};
                bit_q   <= bit_q + 5'd1;
            end
            if (word_clr) begin
                word_q <= '0;
            end else if (word_inc) begin
                word_q <= word_q + 3'd1;
            end
            // A word arriving after an underrun starts a new refresh.
            if (urun_nxt) begin
                idx_q <= '0;
            end else if (accept) begin
                idx_q <= (idx_q == LAST_W) ? 3'd0 : idx_q + 3'd1;
            end
        end
    end

endmodule

// File: tb/tb_ws2812_bit_encoder.sv
// Scoreboard bench for ws2812_bit_encoder: random words, expected pulses
// queued at issue time and checked by an independent line monitor.
module tb_ws2812_bit_encoder;

    localparam int T0 = 2;
    localparam int T1 = 4;
    localparam int BC = 6;
    localparam int RC = 10;
    localparam int LC = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [23:0] frame_in = '0;
    logic        frame_valid = 1'b0;
    logic        frame_ready;
    logic [2:0]  led_index;
    logic        dout;
    logic        busy;
    logic        frame_done;
    logic        underrun;

    ws2812_bit_encoder #(
        .T0H_CYC   (T0),
        .T1H_CYC   (T1),
        .BIT_CYC   (BC),
        .RESET_CYC (RC),
        .LED_COUNT (LC)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .frame_in    (frame_in),
        .frame_valid (frame_valid),
        .frame_ready (frame_ready),
        .led_index   (led_index),
        .dout        (dout),
        .busy        (busy),
        .frame_done  (frame_done),
        .underrun    (underrun)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic b;
        logic last;
    } bit_t;

    int   checks = 0;
    int   errors = 0;
    bit_t exp_q[$];
    bit   end_q[$];
    int   ends = 0;
    int   exp_ends = 0;

    function automatic logic [23:0] map_word(input logic [23:0] w);
        logic [7:0] r, g, b;
        r = w[23:16];
        g = w[15:8];
        b = w[7:0];
`ifdef WS2812_GRB_ORDER_EN
        return {g, r, b};
`else
        return {r, g, b};
`endif
    endfunction

    // Line monitor: times every pulse and the end-of-refresh events.
    int   cyc = 0, last_rise = 0, end_rise = 0, hi = 0;
    bit   have_prev = 0, pend = 0, pend_urun = 0, dout_prev = 0;
    bit_t cur = '0;

    always @(negedge clk) begin
        if (!rst_n) begin
            have_prev = 0;
            pend = 0;
            dout_prev = 0;
            hi = 0;
        end else begin
            bit exp_u, exp_d;
            int exp_hi;
            cyc++;
            if (dout && !dout_prev) begin
                if (pend) begin
                    errors++;
                    $display("FAIL latch_rise: pulse at cycle %0d, latch began %0d",
                             cyc, end_rise);
                end
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL extra_bit: pulse at cycle %0d, none expected", cyc);
                end else begin
                    cur = exp_q.pop_front();
                    if (have_prev) begin
                        checks++;
                        if (cyc - last_rise != BC) begin
                            errors++;
                            $display("FAIL bit_period: got %0d want %0d",
                                     cyc - last_rise, BC);
                        end
                    end
                    checks++;
                    if (busy !== 1'b1) begin
                        errors++;
                        $display("FAIL busy_bit: got %b want 1", busy);
                    end
                    have_prev = !cur.last;
                    last_rise = cyc;
                    if (cur.last) begin
                        pend = 1;
                        pend_urun = (end_q.size() != 0) ? end_q.pop_front() : 1'b0;
                        end_rise = cyc;
                    end
                end
                hi = 0;
            end
            if (dout) hi++;
            if (!dout && dout_prev) begin
                exp_hi = cur.b ? T1 : T0;
                checks++;
                if (hi != exp_hi) begin
                    errors++;
                    $display("FAIL high_time: got %0d want %0d", hi, exp_hi);
                end
            end
            exp_u = pend && pend_urun && (cyc == end_rise + BC);
            exp_d = pend && (cyc == end_rise + BC + RC);
            if (underrun || exp_u) begin
                checks++;
                if (underrun !== exp_u) begin
                    errors++;
                    $display("FAIL underrun: got %b want %b at cycle %0d",
                             underrun, exp_u, cyc);
                end
            end
            if (frame_done || exp_d) begin
                checks++;
                if (frame_done !== exp_d) begin
                    errors++;
                    $display("FAIL frame_done: got %b want %b at cycle %0d",
                             frame_done, exp_d, cyc);
                end
            end
            if (exp_d) begin
                checks++;
                if (busy !== 1'b0) begin
                    errors++;
                    $display("FAIL busy_done: got %b want 0", busy);
                end
                pend = 0;
                ends++;
            end
            dout_prev = dout;
        end
    end

    // Called just after a negedge; returns just after a negedge.
    task automatic send_word(input logic [23:0] w, input int pos,
                             input bit last, input bit urun, input bit hold);
        logic [23:0] m;
        bit ok;
        m = map_word(w);
        for (int i = 23; i >= 0; i--) begin
            exp_q.push_back('{b: m[i], last: (last && i == 0)});
        end
        if (last) end_q.push_back(urun);
        frame_in = w;
        frame_valid = 1'b1;
        ok = 0;
        for (int n = 0; n < 2000; n++) begin
            if (frame_ready) begin
                ok = 1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) begin
            errors++;
            $display("FAIL accept_timeout: word %h never accepted", w);
            frame_valid = 1'b0;
            return;
        end
        checks++;
        if (led_index !== 3'(pos)) begin
            errors++;
            $display("FAIL led_index: got %0d want %0d", led_index, pos);
        end
        @(posedge clk);
        #1;
        if (!hold) frame_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (frame_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_ready: got %b want 0 while holding full", frame_ready);
        end
    endtask

    task automatic wait_ends();
        bit ok;
        ok = 0;
        for (int n = 0; n < 4000; n++) begin
            if (ends >= exp_ends) begin
                ok = 1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) begin
            errors++;
            $display("FAIL end_timeout: got %0d refresh ends want %0d", ends, exp_ends);
        end
    endtask

    task automatic refresh(input logic [23:0] w0, input logic [23:0] w1,
                           input bit full, input bit hold, input bit wt);
        if (full) begin
            send_word(w0, 0, 1'b0, 1'b0, hold);
            if (!hold) repeat ($urandom_range(0, 3)) @(negedge clk);
            send_word(w1, 1, 1'b1, 1'b0, hold);
        end else begin
            send_word(w0, 0, 1'b1, 1'b1, 1'b0);
        end
        exp_ends++;
        if (wt) wait_ends();
    endtask

    task automatic check_idx0(input string tag);
        checks++;
        if (led_index !== 3'd0) begin
            errors++;
            $display("FAIL %s: led_index got %0d want 0", tag, led_index);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clk);
        checks += 6;
        if (dout !== 1'b0) begin errors++; $display("FAIL rst_dout: got %b want 0", dout); end
        if (frame_ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b want 1", frame_ready); end
        if (led_index !== 3'd0) begin errors++; $display("FAIL rst_idx: got %0d want 0", led_index); end
        if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
        if (frame_done !== 1'b0) begin errors++; $display("FAIL rst_done: got %b want 0", frame_done); end
        if (underrun !== 1'b0) begin errors++; $display("FAIL rst_urun: got %b want 0", underrun); end
        rst_n = 1'b1;
        @(negedge clk);

        refresh(24'hA00000, 24'h000001, 1'b1, 1'b0, 1'b1);
        check_idx0("idx_after_refresh");

        refresh(24'(($urandom)), 24'h0, 1'b0, 1'b0, 1'b1);
        check_idx0("idx_after_underrun");

        refresh(24'hFF0000, 24'($urandom), 1'b1, 1'b0, 1'b1);

        // Reset in the middle of bit 5 of word 0, while dout is high.
        send_word(24'hFFFFFF, 0, 1'b0, 1'b0, 1'b0);
        send_word(24'($urandom), 1, 1'b1, 1'b0, 1'b0);
        repeat (30) @(posedge clk);
        #2;
        checks++;
        if (dout !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_dout: got %b want 1", dout);
        end
        rst_n = 1'b0;
        #1;
        checks += 4;
        if (dout !== 1'b0) begin errors++; $display("FAIL mid_rst_dout: got %b want 0", dout); end
        if (frame_ready !== 1'b1) begin errors++; $display("FAIL mid_rst_ready: got %b want 1", frame_ready); end
        if (led_index !== 3'd0) begin errors++; $display("FAIL mid_rst_idx: got %0d want 0", led_index); end
        if (busy !== 1'b0) begin errors++; $display("FAIL mid_rst_busy: got %b want 0", busy); end
        exp_q.delete();
        end_q.delete();
        exp_ends = ends;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        refresh(24'($urandom), 24'($urandom), 1'b1, 1'b0, 1'b1);

        for (int r = 0; r < 8; r++) begin
            refresh(24'($urandom), 24'($urandom), bit'($urandom_range(0, 1)),
                    1'b0, 1'b1);
            repeat ($urandom_range(0, 4)) @(negedge clk);
        end

        // Stalled source: valid held high across three refreshes.
        for (int r = 0; r < 3; r++) begin
            refresh(24'($urandom), 24'($urandom), 1'b1, 1'b1, 1'b0);
        end
        frame_valid = 1'b0;
        wait_ends();
        check_idx0("idx_after_stream");

        repeat (5) @(negedge clk);
        checks++;
        if (exp_q.size() != 0 || pend) begin
            errors++;
            $display("FAIL leftover: got %0d bits pending want 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
